// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute control unit for the register-register ALU datapath.
// Optional macro SEQ_SINGLE_STEP_EN adds a 'step' input that gates every state transition.
module alu_control_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             ZHIout,
    output logic             ZLOout,
    output logic             HIin,
    output logic             LOin,
    output logic             Rin,
    output logic             Rout,
    output logic [3:0]       reg_sel,
    output logic [4:0]       opcode,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state, state_next;

    logic       adv;
    logic       retire;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_halt, is_nop, is_binary, is_muldiv, is_unary;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

`ifdef SEQ_SINGLE_STEP_EN
    assign adv = run & step;
`else
    assign adv = run;
`endif

    assign is_halt   = (op == HALT_OP);
    assign is_nop    = !is_halt && (op == 5'd0);
    assign is_binary = !is_halt && (op >= 5'd1) && (op <= 5'd9);
    assign is_muldiv = !is_halt && ((op == 5'd10) || (op == 5'd11));
    assign is_unary  = !is_halt && ((op == 5'd12) || (op == 5'd13));

    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Strobes are a pure decode of state and ir; a paused cycle (adv low) holds state with all strobes low.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZHighIn    = 1'b0;
        ZLowIn     = 1'b0;
        ZHIout     = 1'b0;
        ZLOout     = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        reg_sel    = 4'd0;
        opcode     = 5'd0;
        illegal    = 1'b0;

        case (state)
            IDLE: if (adv) state_next = T0;
            T0: if (adv) begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                state_next = T1;
            end
            T1: if (adv) begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready)
                    state_next = T2;
            end
            T2: if (adv) begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = T3;
            end
            T3: if (adv) begin
                if (is_halt) begin
                    state_next = HALT;
                end else if (is_nop) begin
                    retire     = 1'b1;
                    state_next = T0;
                end else if (is_binary || is_muldiv) begin
                    Rout       = 1'b1;
                    reg_sel    = rb;
                    Yin        = 1'b1;
                    state_next = T4;
                end else if (is_unary) begin
                    state_next = T4;
                end else begin
                    illegal    = 1'b1;
                    state_next = T0;
                end
            end
            T4: begin
                opcode = op;
                if (adv) begin
                    Rout       = 1'b1;
                    reg_sel    = is_unary ? rb : rc;
                    ZLowIn     = 1'b1;
                    ZHighIn    = 1'b1;
                    state_next = T5;
                end
            end
            T5: if (adv) begin
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    state_next = T6;
                end else begin
                    Rin        = 1'b1;
                    reg_sel    = ra;
                    retire     = 1'b1;
                    state_next = T0;
                end
            end
            T6: if (adv) begin
                ZHIout     = 1'b1;
                HIin       = 1'b1;
                retire     = 1'b1;
                state_next = T0;
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired control unit that drives the strobe and select inputs of the CPU datapath for instruction fetch and register-register ALU instructions.
- Replaces the hand-sequenced T0..T5 stimulus currently used to exercise the datapath.
- Sits directly upstream of the datapath: consumes its IR contents and a memory-ready flag, and produces every Rin/Rout, Yin, Z, MDR, MAR, PC and opcode control for one T-state per clock.

Parameters:
- CNT_W, 16, width of the retired-instruction counter
- HALT_OP, 5'b11111, opcode field value that stops the sequencer

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  reset; synchronous, active-high
- run  in  1  sequencer advances only while high
- ir  in  32  datapath IR contents; fields op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
- mem_ready  in  1  memory read data valid on Mdatain
- PCout, MARin, IncPC, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes
- Yin, ZHighIn, ZLowIn, ZHIout, ZLOout, HIin, LOin  out  1 each  execute strobes
- Rin, Rout  out  1 each  general-register write/drive enables
- reg_sel  out  4  general-register index qualifying Rin/Rout
- opcode  out  5  ALU operation select to datapath
- halted  out  1  high once HALT_OP executed
- illegal  out  1  one-cycle pulse on undefined opcode
- instr_count  out  CNT_W  instructions retired

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. The state register is the only sequential control element; all strobes are a combinational decode of state and ir and are held for the whole state (one clk).
- Reset (clr=1 at a rising edge): state=IDLE, instr_count=0, halted=0. Every strobe, reg_sel, opcode and illegal are 0 while in IDLE.
- clr has priority over every other input in every state, including mid-instruction. No strobe is asserted in the cycle after reset.
- IDLE -> T0 when run=1. In any state T0..T6, run=0 freezes the state and forces all strobes to 0. Execution resumes in the same state when run returns to 1.
- T0: PCout, MARin, IncPC. -> T1.
- T1: Read, MDRin. Stays in T1 while mem_ready=0. -> T2 on a cycle with mem_ready=1.
- T2: MDRout, IRin. -> T3. ir is sampled from T3 onward.
- Opcodes: 00000 nop; 00001 add; 00010 sub; 00011 and; 00100 or; 00101 shr; 00110 shra; 00111 shl; 01000 ror; 01001 rol; 01010 mul; 01011 div; 01100 neg; 01101 not; HALT_OP.
- During T4, opcode = ir[31:27]. Otherwise opcode = 0.
- Binary ops (add..rol):
  - T3: Rout, reg_sel=rb, Yin.
  - T4: Rout, reg_sel=rc, ZLowIn, ZHighIn.
  - T5: ZLOout, Rin, reg_sel=ra.
  - -> T0.
- mul/div: T3 and T4 as for binary ops; T5: ZLOout, LOin; T6: ZHIout, HIin; -> T0. ra is ignored.
- neg/not: T3 has no strobes. T4: Rout, reg_sel=rb, ZLowIn, ZHighIn. T5: ZLOout, Rin, reg_sel=ra. -> T0.
- nop: T3 -> T0 with no strobes.
- HALT_OP: T3 -> HALT. halted=1 until clr. run is ignored in HALT.
- Undefined opcode: in T3, illegal=1 for exactly one cycle, no other strobes, -> T0. instr_count is not incremented.
- instr_count increments by 1 on the transition into T0 from the last execute state of any defined non-halt instruction. It wraps from all-ones to 0.
- reg_sel = 0 whenever Rin and Rout are both 0.

Optional Feature:
- SEQ_SINGLE_STEP_EN: adds input step (1 bit).
- With the macro defined: a transition between states occurs only on a cycle where run=1 and step=1. step=0 holds the current state with strobes suppressed, exactly as for run=0. This gives one T-state per step pulse for bring-up.
- Without the macro: no step port exists, and state advances every cycle while run=1.

Test Plan:
- Reset, then run=1, mem_ready=1, ir=32'h08A18000 (add r1,r4,r3) -> T0..T5 take 6 cycles. In T3, Rout with reg_sel=4 and Yin; in T4, opcode=00001 with reg_sel=3 and ZLowIn; in T5, Rin with reg_sel=1. instr_count=1 on return to T0.
- mem_ready held 0 for 3 cycles in T1 -> Read and MDRin high for 4 cycles total, then T2 follows. No IRin before mem_ready=1.
- ir opcode=01010 (mul) -> T6 is visited: ZLOout+LOin in T5, ZHIout+HIin in T6. Rin stays 0 throughout.
- ir opcode=10101 -> illegal pulses for 1 cycle in T3, next state is T0, instr_count is unchanged.
- clr=1 asserted in T4 -> next cycle state=IDLE, all outputs 0, instr_count=0. ir opcode=HALT_OP -> halted=1 and stays high while run toggles.
- run dropped to 0 in T4 for 2 cycles -> strobes 0 during the pause, and T4 strobes reappear when run returns to 1.
